// File: rtl/lcd_id_ctrl.sv
// Power-up sequencer: releases the RGB bus, debounces the M2/M1/M0 panel straps,
// decodes the panel ID, then returns the bus to the driver and enables the backlight.
//
//   state  | meaning
//   SETTLE | bus released, waiting for the strap pins to settle
//   SAMPLE | bus released, debouncing the synchronised strap code
//   DONE   | known ID latched, bus driven, backlight delay running
//   ERR    | unstable or unknown strap code, backlight held off
module lcd_id_ctrl #(
  parameter int SETTLE_CYC = 1000,
  parameter int STABLE_CYC = 16,
  parameter int MAX_GLITCH = 8,
  parameter int BL_DELAY   = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] i_lcd_rgb_in,
  input  logic        i_rescan,
  output logic        o_lcd_rgb_oe,
  output logic [15:0] o_lcd_id,
  output logic        o_id_valid,
  output logic        o_id_err,
  output logic        o_lcd_bl
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(STABLE_CYC + 1);
  localparam int GW = $clog2(MAX_GLITCH + 1);
  localparam int BW = $clog2(BL_DELAY + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYC - 1);
  localparam logic [GW-1:0] GLITCH_LAST = GW'(MAX_GLITCH - 1);
  localparam logic [BW-1:0] BL_LAST     = BW'(BL_DELAY - 1);
  localparam logic [BW-1:0] BL_FULL     = BW'(BL_DELAY);

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  logic [1:0]    r_state;
  logic [2:0]    r_sync1, r_sync2, r_prev;
  logic          r_first;
  logic [SW-1:0] r_cnt;
  logic [TW-1:0] r_stable;
  logic [GW-1:0] r_glitch;
  logic [BW-1:0] r_bl_cnt;
  logic          r_oe, r_valid, r_err, r_bl;
  logic [15:0]   r_id;

  logic [2:0]    w_code;
  logic          w_match;
  logic [15:0]   w_dec_id;
  logic          w_dec_ok;

  assign w_code  = r_sync2;
  assign w_match = (w_code == r_prev);

  always_comb begin
    w_dec_id = 16'h0000;
    w_dec_ok = 1'b1;
    case (w_code)
      3'b000:  w_dec_id = 16'h4342;
      3'b001:  w_dec_id = 16'h7084;
      3'b010:  w_dec_id = 16'h7016;
      3'b100:  w_dec_id = 16'h4384;
      3'b101:  w_dec_id = 16'h1018;
      default: w_dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_SETTLE;
      r_sync1  <= 3'b000;
      r_sync2  <= 3'b000;
      r_prev   <= 3'b000;
      r_first  <= 1'b0;
      r_cnt    <= '0;
      r_stable <= '0;
      r_glitch <= '0;
      r_bl_cnt <= '0;
      r_oe     <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_bl     <= 1'b0;
      r_id     <= 16'h0000;
    end else begin
      // M2/M1/M0 live on the MSB of each colour byte
      r_sync1 <= {i_lcd_rgb_in[7], i_lcd_rgb_in[15], i_lcd_rgb_in[23]};
      r_sync2 <= r_sync1;
      case (r_state)
        ST_SETTLE: begin
          r_oe <= 1'b0;
          if (r_cnt == SETTLE_LAST) begin
            r_cnt    <= '0;
            r_stable <= '0;
            r_glitch <= '0;
            r_first  <= 1'b1;
            r_state  <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          r_oe <= 1'b0;
          if (r_first) begin
            r_first  <= 1'b0;
            r_prev   <= w_code;
            r_stable <= TW'(1);
          end else if (w_match) begin
            r_stable <= r_stable + 1'b1;
            if (r_stable == STABLE_LAST) begin
              r_id     <= w_dec_id;
              r_valid  <= 1'b1;
              r_oe     <= 1'b1;
              r_err    <= !w_dec_ok;
              r_bl_cnt <= '0;
              r_state  <= w_dec_ok ? ST_DONE : ST_ERR;
            end
          end else begin
            r_prev   <= w_code;
            r_stable <= TW'(1);
            r_glitch <= r_glitch + 1'b1;
            if (r_glitch == GLITCH_LAST) begin
              r_id    <= 16'h0000;
              r_valid <= 1'b1;
              r_oe    <= 1'b1;
              r_err   <= 1'b1;
              r_state <= ST_ERR;
            end
          end
        end
        ST_DONE, ST_ERR: begin
          if (i_rescan) begin
            r_state  <= ST_SETTLE;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_bl     <= 1'b0;
            r_oe     <= 1'b0;
            r_cnt    <= '0;
            r_stable <= '0;
            r_glitch <= '0;
            r_bl_cnt <= '0;
            r_first  <= 1'b0;
          end else if (r_state == ST_DONE) begin
            if (r_bl_cnt != BL_FULL) r_bl_cnt <= r_bl_cnt + 1'b1;
            if (r_bl_cnt == BL_LAST) r_bl <= 1'b1;
          end
        end
        default: r_state <= ST_SETTLE;
      endcase
    end
  end

  assign o_lcd_rgb_oe = r_oe;
  assign o_lcd_id     = r_id;
  assign o_id_valid   = r_valid;
  assign o_id_err     = r_err;
  assign o_lcd_bl     = r_bl;

endmodule

// File: tb/tb_lcd_id_ctrl.sv
// Directed bench for lcd_id_ctrl with short timing parameters and hand-computed
// valid/backlight latencies counted from reset release or rescan.
module tb_lcd_id_ctrl;

  logic        clk;
  logic        rst_n;
  logic [23:0] i_lcd_rgb_in;
  logic        i_rescan;
  logic        o_lcd_rgb_oe;
  logic [15:0] o_lcd_id;
  logic        o_id_valid;
  logic        o_id_err;
  logic        o_lcd_bl;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_id_ctrl #(
    .SETTLE_CYC(8),
    .STABLE_CYC(4),
    .MAX_GLITCH(3),
    .BL_DELAY(5)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_lcd_rgb_in (i_lcd_rgb_in),
    .i_rescan     (i_rescan),
    .o_lcd_rgb_oe (o_lcd_rgb_oe),
    .o_lcd_id     (o_lcd_id),
    .o_id_valid   (o_id_valid),
    .o_id_err     (o_id_err),
    .o_lcd_bl     (o_lcd_bl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // straps on bits 7/15/23; other bits carry a fixed pattern that must be ignored
  task automatic drive_code(input logic [2:0] c);
    logic [23:0] v;
    v = 24'h5A3C69 & ~24'h808080;
    v[7]  = c[2];
    v[15] = c[1];
    v[23] = c[0];
    i_lcd_rgb_in = v;
  endtask

  task automatic do_reset(input logic [2:0] c);
    rst_n    = 1'b0;
    i_rescan = 1'b0;
    drive_code(c);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0: steady a; mode 1: one-cycle excursion to b after cycle 9; mode 2: a/b every 2 cycles.
  // rescan is pulsed in SETTLE and SAMPLE and must be ignored there.
  task automatic run_seq(input int mode, input logic [2:0] a, input logic [2:0] b, output int cyc);
    logic oe_ok;
    oe_ok = 1'b1;
    cyc   = -1;
    drive_code(a);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      i_rescan = 1'b0;
      if (o_id_valid) begin
        cyc = n;
        break;
      end
      if (o_lcd_rgb_oe) oe_ok = 1'b0;
      if (n == 3 || n == 10) i_rescan = 1'b1;
      if (mode == 1) begin
        if (n == 9)  drive_code(b);
        if (n == 10) drive_code(a);
      end
      if (mode == 2 && (n % 2) == 0) drive_code(((n / 2) % 2) == 1 ? b : a);
    end
    chk("oe_low_while_reading", {31'd0, oe_ok}, 32'd1);
  endtask

  task automatic count_bl(output int c);
    c = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (o_lcd_bl) begin
        c = n;
        break;
      end
    end
  endtask

  task automatic bl_stays_off(input string tag);
    logic ok;
    ok = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (o_lcd_bl) ok = 1'b0;
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  int cyc;

  initial begin
    rst_n        = 1'b0;
    i_rescan     = 1'b0;
    i_lcd_rgb_in = 24'h0;

    // reset values
    do_reset(3'b001);
    chk("rst_oe",    {31'd0, o_lcd_rgb_oe}, 32'd0);
    chk("rst_id",    {16'd0, o_lcd_id},     32'h0);
    chk("rst_valid", {31'd0, o_id_valid},   32'd0);
    chk("rst_err",   {31'd0, o_id_err},     32'd0);
    chk("rst_bl",    {31'd0, o_lcd_bl},     32'd0);

    // 1: steady 001
    run_seq(0, 3'b001, 3'b001, cyc);
    chk("s1_valid_cyc", cyc,                 32'd12);
    chk("s1_id",        {16'd0, o_lcd_id},   32'h7084);
    chk("s1_err",       {31'd0, o_id_err},   32'd0);
    chk("s1_oe",        {31'd0, o_lcd_rgb_oe}, 32'd1);
    chk("s1_bl_early",  {31'd0, o_lcd_bl},   32'd0);
    count_bl(cyc);
    chk("s1_bl_delay",  cyc, 32'd5);

    // 2: 101 with a single excursion to 100
    do_reset(3'b101);
    run_seq(1, 3'b101, 3'b100, cyc);
    chk("s2_valid_cyc", cyc,               32'd16);
    chk("s2_id",        {16'd0, o_lcd_id}, 32'h1018);
    chk("s2_err",       {31'd0, o_id_err}, 32'd0);

    // 3: toggling straps exhaust the glitch budget
    do_reset(3'b000);
    run_seq(2, 3'b000, 3'b001, cyc);
    chk("s3_reached",   {31'd0, (cyc > 0) ? 1'b1 : 1'b0}, 32'd1);
    chk("s3_err",       {31'd0, o_id_err},   32'd1);
    chk("s3_id",        {16'd0, o_lcd_id},   32'h0);
    chk("s3_oe",        {31'd0, o_lcd_rgb_oe}, 32'd1);
    bl_stays_off("s3_bl_off");

    // 4: unknown code 011
    do_reset(3'b011);
    run_seq(0, 3'b011, 3'b011, cyc);
    chk("s4_valid_cyc", cyc,               32'd12);
    chk("s4_err",       {31'd0, o_id_err}, 32'd1);
    chk("s4_id",        {16'd0, o_lcd_id}, 32'h0);
    bl_stays_off("s4_bl_off");

    // 5: rescan from DONE after changing straps
    do_reset(3'b000);
    run_seq(0, 3'b000, 3'b000, cyc);
    chk("s5_valid_cyc", cyc,               32'd12);
    chk("s5_id_first",  {16'd0, o_lcd_id}, 32'h4342);
    count_bl(cyc);
    chk("s5_bl_delay",  cyc, 32'd5);
    drive_code(3'b010);
    repeat (3) @(posedge clk);
    #1 i_rescan = 1'b1;
    @(posedge clk);
    #1 i_rescan = 1'b0;
    chk("s5_rescan_oe",    {31'd0, o_lcd_rgb_oe}, 32'd0);
    chk("s5_rescan_valid", {31'd0, o_id_valid},   32'd0);
    chk("s5_rescan_bl",    {31'd0, o_lcd_bl},     32'd0);
    chk("s5_rescan_hold",  {16'd0, o_lcd_id},     32'h4342);
    run_seq(0, 3'b010, 3'b010, cyc);
    chk("s5_revalid_cyc", cyc,               32'd12);
    chk("s5_id_second",   {16'd0, o_lcd_id}, 32'h7016);

    // 6a: async reset during SAMPLE
    do_reset(3'b100);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s6a_oe",    {31'd0, o_lcd_rgb_oe}, 32'd0);
    chk("s6a_valid", {31'd0, o_id_valid},   32'd0);
    chk("s6a_id",    {16'd0, o_lcd_id},     32'h0);

    // 6b: async reset during the backlight wait, then a full sequence
    do_reset(3'b100);
    run_seq(0, 3'b100, 3'b100, cyc);
    chk("s6b_valid_cyc", cyc,               32'd12);
    chk("s6b_id",        {16'd0, o_lcd_id}, 32'h4384);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s6b_rst_oe",    {31'd0, o_lcd_rgb_oe}, 32'd0);
    chk("s6b_rst_valid", {31'd0, o_id_valid},   32'd0);
    chk("s6b_rst_id",    {16'd0, o_lcd_id},     32'h0);
    chk("s6b_rst_bl",    {31'd0, o_lcd_bl},     32'd0);
    do_reset(3'b100);
    run_seq(0, 3'b100, 3'b100, cyc);
    chk("s6b_again_cyc", cyc,               32'd12);
    chk("s6b_again_id",  {16'd0, o_lcd_id}, 32'h4384);
    count_bl(cyc);
    chk("s6b_bl_delay",  cyc, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
